// File: rtl/coreuart_fifo_sync.sv
// rtl/coreuart_fifo_sync.sv - parametrised synchronous FIFO with thresholds; sticky error flags under COREUART_FIFO_ERR_FLAGS_EN
module coreuart_fifo_sync #(
    parameter int FIFO_WIDTH = 8,
    parameter int FIFO_DEPTH = 128,
    parameter int FIFO_BITS  = 7
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  write_n,
    input  logic                  read_n,
    input  logic [FIFO_BITS:0]    hi_level,
    input  logic [FIFO_BITS:0]    lo_level,
    input  logic                  err_clr,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic [FIFO_BITS:0]    count,
    output logic                  full,
    output logic                  empty,
    output logic                  half,
    output logic                  low,
    output logic                  overflow,
    output logic                  underflow
);

    // Pointers wrap explicitly at the last slot so non-power-of-two depths work.
    localparam logic [FIFO_BITS-1:0] LAST_PTR   = FIFO_BITS'(FIFO_DEPTH - 1);
    localparam logic [FIFO_BITS:0]   FULL_COUNT = (FIFO_BITS + 1)'(FIFO_DEPTH);

    logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [FIFO_BITS-1:0]  wr_ptr_q,   wr_ptr_d;
    logic [FIFO_BITS-1:0]  rd_ptr_q,   rd_ptr_d;
    logic [FIFO_BITS:0]    count_q,    count_d;
    logic [FIFO_WIDTH-1:0] data_out_q, data_out_d;

    logic rd_accept;
    logic wr_accept;

    assign count    = count_q;
    assign data_out = data_out_q;

    // Status flags are decoded from the registered count; thresholds act immediately.
    always_comb begin
        full  = (count_q == FULL_COUNT);
        empty = (count_q == '0);
        half  = (count_q >= hi_level);
        low   = (count_q <= lo_level);
    end

    // A write at full is still accepted when a read frees a slot in the same cycle.
    always_comb begin
        rd_accept = !read_n && !empty;
        wr_accept = !write_n && (!full || rd_accept);
    end

    // Next-state for pointers, occupancy and the registered read port.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;
        if (wr_accept) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (rd_accept) begin
            rd_ptr_d   = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            data_out_d = mem_q[rd_ptr_q];
        end
        case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
        end
    end

    // Storage array; contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (!reset && wr_accept) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

`ifdef COREUART_FIFO_ERR_FLAGS_EN
    logic overflow_q,  overflow_d;
    logic underflow_q, underflow_d;

    // Sticky error flags: a new rejection outranks err_clr in the same cycle.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (!write_n && !wr_accept) begin
            overflow_d = 1'b1;
        end
        if (!read_n && !rd_accept) begin
            underflow_d = 1'b1;
        end
    end

    // Error flag registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    logic err_clr_unused;

    assign err_clr_unused = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule
